// File: rtl/msrv32_wb_write_buffer.sv
// In-order writeback FIFO in front of the register file write port.
// Pending results (queued or in the output stage) are forwarded to operand fetch.
module msrv32_wb_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_in,
   input  logic             alu_wr_valid_in,
   input  logic [4:0]       alu_rd_addr_in,
   input  logic [31:0]      alu_rd_data_in,
   output logic             alu_wr_ready_out,
   input  logic             lsu_wr_valid_in,
   input  logic [4:0]       lsu_rd_addr_in,
   input  logic [31:0]      lsu_rd_data_in,
   output logic             lsu_wr_ready_out,
   input  logic             wb_stall_in,
   output logic             wr_en_out,
   output logic [4:0]       rd_addr_out,
   output logic [31:0]      rd_out,
   input  logic [4:0]       rs_1_addr_in,
   input  logic [4:0]       rs_2_addr_in,
   output logic             rs_1_pending_out,
   output logic [31:0]      rs_1_fwd_out,
   output logic             rs_2_pending_out,
   output logic [31:0]      rs_2_fwd_out,
   output logic [PTR_W:0]   count_out,
   output logic             full_out,
   output logic             empty_out
);

   localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

   logic [4:0]       addrMem_q [DEPTH];
   logic [31:0]      dataMem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             outValid_q;
   logic [4:0]       outAddr_q;
   logic [31:0]      outData_q;

   logic             full;
   logic             empty;
   logic             lsuAccept;
   logic             aluAccept;
   logic             push;
   logic             pop;
   logic [4:0]       pushAddr;
   logic [31:0]      pushData;

   // A completed handshake to x0 is swallowed without occupying a slot.
   always_comb begin
      full      = (count_q == FullCount);
      empty     = (count_q == '0);
      lsuAccept = lsu_wr_valid_in && !full;
      aluAccept = alu_wr_valid_in && !full && !lsu_wr_valid_in;
      pushAddr  = lsu_wr_valid_in ? lsu_rd_addr_in : alu_rd_addr_in;
      pushData  = lsu_wr_valid_in ? lsu_rd_data_in : alu_rd_data_in;
      push      = (lsuAccept || aluAccept) && (pushAddr != 5'd0);
      pop       = !wb_stall_in && !empty;
      count_d   = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         outValid_q <= 1'b0;
         outAddr_q  <= '0;
         outData_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (!wb_stall_in) begin
            outValid_q <= pop;
            if (pop) begin
               outAddr_q <= addrMem_q[rdPtr_q];
               outData_q <= dataMem_q[rdPtr_q];
               rdPtr_q   <= rdPtr_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (push) begin
         addrMem_q[wrPtr_q] <= pushAddr;
         dataMem_q[wrPtr_q] <= pushData;
      end
   end

   // Oldest candidate is visited first so later (younger) matches overwrite it.
   always_comb begin
      logic [PTR_W-1:0] slot;
      slot             = '0;
      rs_1_pending_out = 1'b0;
      rs_1_fwd_out     = '0;
      rs_2_pending_out = 1'b0;
      rs_2_fwd_out     = '0;
      if (outValid_q && rs_1_addr_in != 5'd0 && outAddr_q == rs_1_addr_in) begin
         rs_1_pending_out = 1'b1;
         rs_1_fwd_out     = outData_q;
      end
      if (outValid_q && rs_2_addr_in != 5'd0 && outAddr_q == rs_2_addr_in) begin
         rs_2_pending_out = 1'b1;
         rs_2_fwd_out     = outData_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot = rdPtr_q + PTR_W'(i);
         if ((PTR_W+1)'(i) < count_q) begin
            if (rs_1_addr_in != 5'd0 && addrMem_q[slot] == rs_1_addr_in) begin
               rs_1_pending_out = 1'b1;
               rs_1_fwd_out     = dataMem_q[slot];
            end
            if (rs_2_addr_in != 5'd0 && addrMem_q[slot] == rs_2_addr_in) begin
               rs_2_pending_out = 1'b1;
               rs_2_fwd_out     = dataMem_q[slot];
            end
         end
      end
   end

   assign lsu_wr_ready_out = !full;
   assign alu_wr_ready_out = !full && !lsu_wr_valid_in;
   assign wr_en_out        = outValid_q;
   assign rd_addr_out      = outAddr_q;
   assign rd_out           = outData_q;
   assign count_out        = count_q;
   assign full_out         = full;
   assign empty_out        = empty;

endmodule

// File: tb/tb_msrv32_wb_write_buffer.sv
// Bench for msrv32_wb_write_buffer: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_msrv32_wb_write_buffer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clock = 1'b0;
   logic             resetN;
   logic             aluValid, lsuValid, stall;
   logic [4:0]       aluAddr, lsuAddr, rs1Addr, rs2Addr;
   logic [31:0]      aluData, lsuData;
   logic             aluReady, lsuReady, wrEn, rs1Pend, rs2Pend, fullFlag, emptyFlag;
   logic [4:0]       rdAddr;
   logic [31:0]      rdData, rs1Fwd, rs2Fwd;
   logic [PTR_W:0]   count;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } entry_t;

   entry_t      mq[$];
   logic        mOutV;
   logic [4:0]  mOutA;
   logic [31:0] mOutD;

   int checkCount = 0;
   int passCount  = 0;

   msrv32_wb_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .ms_riscv32_mp_clk_in (clock),
      .ms_riscv32_mp_rst_in (resetN),
      .alu_wr_valid_in      (aluValid),
      .alu_rd_addr_in       (aluAddr),
      .alu_rd_data_in       (aluData),
      .alu_wr_ready_out     (aluReady),
      .lsu_wr_valid_in      (lsuValid),
      .lsu_rd_addr_in       (lsuAddr),
      .lsu_rd_data_in       (lsuData),
      .lsu_wr_ready_out     (lsuReady),
      .wb_stall_in          (stall),
      .wr_en_out            (wrEn),
      .rd_addr_out          (rdAddr),
      .rd_out               (rdData),
      .rs_1_addr_in         (rs1Addr),
      .rs_2_addr_in         (rs2Addr),
      .rs_1_pending_out     (rs1Pend),
      .rs_1_fwd_out         (rs1Fwd),
      .rs_2_pending_out     (rs2Pend),
      .rs_2_fwd_out         (rs2Fwd),
      .count_out            (count),
      .full_out             (fullFlag),
      .empty_out            (emptyFlag)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Youngest queued write wins, then the output stage if it is still valid.
   function automatic void lookup(input logic [4:0] r, output logic pend, output logic [31:0] d);
      pend = 1'b0;
      d    = '0;
      if (r != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0 && !pend; i--) begin
            if (mq[i].a == r) begin
               pend = 1'b1;
               d    = mq[i].d;
            end
         end
         if (!pend && mOutV && mOutA == r) begin
            pend = 1'b1;
            d    = mOutD;
         end
      end
   endfunction

   task automatic modelReset();
      mq.delete();
      mOutV = 1'b0;
      mOutA = '0;
      mOutD = '0;
   endtask

   // Advance the model by one rising edge using the inputs held across it.
   task automatic modelEdge();
      bit     isFull;
      bit     acc;
      entry_t e;
      isFull = (mq.size() == DEPTH);
      acc    = (lsuValid && !isFull) || (aluValid && !isFull && !lsuValid);
      e.a    = lsuValid ? lsuAddr : aluAddr;
      e.d    = lsuValid ? lsuData : aluData;
      if (!stall) begin
         if (mq.size() > 0) begin
            entry_t h;
            h     = mq.pop_front();
            mOutV = 1'b1;
            mOutA = h.a;
            mOutD = h.d;
         end else begin
            mOutV = 1'b0;
         end
      end
      if (acc && e.a != 5'd0) mq.push_back(e);
   endtask

   task automatic applyStimulus(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic st, input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clock);
      lsuValid = lv; lsuAddr = la; lsuData = ld;
      aluValid = av; aluAddr = aa; aluData = ad;
      stall    = st; rs1Addr = r1; rs2Addr = r2;
   endtask

   task automatic checkOutput();
      logic        p1, p2;
      logic [31:0] d1, d2;
      bit          isFull;
      isFull = (mq.size() == DEPTH);
      lookup(rs1Addr, p1, d1);
      lookup(rs2Addr, p2, d2);
      check("lsu_ready", lsuReady, !isFull);
      check("alu_ready", aluReady, !isFull && !lsuValid);
      check("wr_en", wrEn, mOutV);
      if (mOutV) begin
         check("rd_addr", rdAddr, mOutA);
         check("rd_out", rdData, mOutD);
      end
      check("count", count, mq.size());
      check("full", fullFlag, isFull);
      check("empty", emptyFlag, mq.size() == 0);
      check("rs1_pend", rs1Pend, p1);
      check("rs1_fwd", rs1Fwd, d1);
      check("rs2_pend", rs2Pend, p2);
      check("rs2_fwd", rs2Fwd, d2);
   endtask

   task automatic cycle(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic st, input logic [4:0] r1, input logic [4:0] r2);
      applyStimulus(lv, la, ld, av, aa, ad, st, r1, r2);
      #1;
      checkOutput();
      @(posedge clock);
      modelEdge();
   endtask

   task automatic checkZeroed(input string tag);
      check({tag, "_wr_en"}, wrEn, 1'b0);
      check({tag, "_rd_addr"}, rdAddr, 5'd0);
      check({tag, "_rd_out"}, rdData, 32'd0);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, emptyFlag, 1'b1);
      check({tag, "_full"}, fullFlag, 1'b0);
   endtask

   initial begin
      resetN = 1'b0;
      lsuValid = 0; lsuAddr = 0; lsuData = 0;
      aluValid = 0; aluAddr = 0; aluData = 0;
      stall = 0; rs1Addr = 0; rs2Addr = 0;
      modelReset();
      #1;
      checkZeroed("reset");
      @(negedge clock);
      resetN = 1'b1;

      $display("[TB] single ALU write and forwarding");
      cycle(0, 0, 0, 1, 5'd1, 32'hA5A5A5A5, 0, 5'd1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 5'd1, 0);
      check("x1_wr_en", wrEn, 1'b0);
      cycle(0, 0, 0, 0, 0, 0, 0, 5'd1, 0);
      check("x1_issued", rdData, 32'hA5A5A5A5);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] LSU priority over ALU");
      cycle(1, 5'd2, 32'h5A5A5A5A, 1, 5'd3, 32'h12345678, 0, 5'd2, 5'd3);
      cycle(0, 0, 0, 1, 5'd3, 32'h12345678, 0, 5'd2, 5'd3);
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 5'd2, 5'd3);

      $display("[TB] fill under stall then drain");
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 5'(6 + i), 32'h600 + i, 1, 5'd7, 5'd9);
      cycle(0, 0, 0, 1, 5'd10, 32'hDEAD, 1, 5'd7, 5'd9);
      check("full_flag", fullFlag, 1'b1);
      repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd9);
      check("drained_empty", emptyFlag, 1'b1);

      $display("[TB] youngest duplicate forwarded");
      cycle(0, 0, 0, 1, 5'd7, 32'hAAAAAAAA, 1, 0, 5'd7);
      cycle(0, 0, 0, 1, 5'd7, 32'h55555555, 1, 0, 5'd7);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 5'd7);
      check("dup_fwd", rs2Fwd, 32'h55555555);
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7);

      $display("[TB] write to x0 dropped");
      cycle(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);

      $display("[TB] asynchronous reset mid-operation");
      cycle(0, 0, 0, 1, 5'd10, 32'h1010, 0, 0, 0);
      cycle(0, 0, 0, 1, 5'd11, 32'h1111, 0, 0, 0);
      cycle(0, 0, 0, 1, 5'd12, 32'h1212, 1, 0, 0);
      cycle(0, 0, 0, 1, 5'd13, 32'h1313, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 5'd10, 0);
      @(negedge clock);
      #2 resetN = 1'b0;
      modelReset();
      #1;
      checkZeroed("async_rst");
      @(negedge clock);
      resetN = 1'b1;
      repeat (5) cycle(0, 0, 0, 0, 0, 0, 0, 5'd11, 5'd12);

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom % 3) == 0, 5'($urandom_range(0, 7)), $urandom,
               ($urandom % 2) == 0, 5'($urandom_range(0, 7)), $urandom,
               ($urandom % 4) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/msrv32_wb_write_buffer.md
Name: msrv32_wb_write_buffer

Overview:
- Writer side of the integer register file write port.
- Accepts writeback requests from the ALU path and the load/store unit, and queues them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's rd_addr/rd/wr_en port.
- Flags and forwards pending (queued or in-flight) results to operand fetch, so reads never see stale data.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- ms_riscv32_mp_clk_in  input  1  single clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low.
- alu_wr_valid_in  input  1  ALU writeback request.
- alu_rd_addr_in  input  5  ALU destination register.
- alu_rd_data_in  input  32  ALU result.
- alu_wr_ready_out  output  1  ALU request accepted this cycle.
- lsu_wr_valid_in  input  1  load writeback request.
- lsu_rd_addr_in  input  5  load destination register.
- lsu_rd_data_in  input  32  load data.
- lsu_wr_ready_out  output  1  load request accepted this cycle.
- wb_stall_in  input  1  register file write port blocked; hold drain.
- wr_en_out  output  1  register file write enable.
- rd_addr_out  output  5  register file write address.
- rd_out  output  32  register file write data.
- rs_1_addr_in  input  5  operand-fetch read address 1 (snooped).
- rs_2_addr_in  input  5  operand-fetch read address 2 (snooped).
- rs_1_pending_out  output  1  youngest pending write to rs_1 exists.
- rs_1_fwd_out  output  32  data of that youngest pending write.
- rs_2_pending_out  output  1  same as rs_1_pending_out, for rs_2.
- rs_2_fwd_out  output  32  same as rs_1_fwd_out, for rs_2.
- count_out  output  PTR_W+1  FIFO occupancy.
- full_out  output  1  count_out == DEPTH.
- empty_out  output  1  count_out == 0.

Behaviour:
Reset (ms_riscv32_mp_rst_in low, asynchronous):
- Pointers, count and the output stage are cleared.
- wr_en_out=0, rd_addr_out=0, rd_out=0, count_out=0, empty_out=1, full_out=0.
- Reset mid-operation discards all queued writes; no partial write is issued.

Enqueue (at most one per cycle):
- Priority: LSU over ALU.
- lsu_wr_ready_out = !full_out.
- alu_wr_ready_out = !full_out && !lsu_wr_valid_in.
- Ready is combinational and does not depend on a same-cycle pop; a full FIFO refuses pushes even while draining.
- Handshake completes when valid && ready at the rising edge.
- Destination x0: the handshake completes but nothing is enqueued and count is unchanged.

Drain:
- The output stage is a register.
- Each edge with !wb_stall_in: if the FIFO is non-empty, pop the head into the output stage (wr_en_out=1, rd_addr_out/rd_out = head); otherwise wr_en_out=0.
- While wb_stall_in=1: the output stage holds its value (wr_en_out held); no pop.
- The register file consumes the output stage at each edge where wr_en_out=1 and !wb_stall_in.

Latency and ordering:
- Request accepted at edge N, FIFO empty, no stall → wr_en_out high for the cycle between edges N+1 and N+2.
- The register file is written at edge N+2.
- Writes issue strictly in acceptance order.

Count:
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.

Forwarding (combinational):
- Search FIFO entries plus the output stage when wr_en_out=1.
- Match on rs_x_addr_in != 0 and equal rd_addr.
- Youngest match wins: the newest FIFO entry first, the output stage last.
- No match or rs_x_addr_in == 0 → pending=0, fwd=0.

Test Plan:
- Reset, then ALU writes x1=0xA5A5A5A5 → one edge later wr_en_out=1, rd_addr_out=1, rd_out=0xA5A5A5A5; during the cycle before that, rs_1_addr_in=1 gives rs_1_pending_out=1, rs_1_fwd_out=0xA5A5A5A5.
- Same cycle, LSU x2=0x5A5A5A5A and ALU x3=0x12345678 → lsu_wr_ready_out=1, alu_wr_ready_out=0; ALU held, accepted next cycle; register file writes issue in order x2 then x3.
- wb_stall_in=1, then 4 ALU writes to x6..x9 → full_out=1, count_out=4, alu_wr_ready_out=0. Release stall → four consecutive wr_en_out pulses x6..x9, then empty_out=1.
- Writes x7=0xAAAAAAAA then x7=0x55555555 queued under stall, rs_2_addr_in=7 → rs_2_fwd_out=0x55555555.
- ALU write to x0 with 0xFFFFFFFF → alu_wr_ready_out=1, count_out stays 0, wr_en_out never asserts; rs_1_addr_in=0 gives pending=0.
- Three writes queued under stall, assert ms_riscv32_mp_rst_in=0 asynchronously mid-cycle → outputs zero immediately and count_out=0. After reset release, no write is ever issued.
